// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encodings and frame constants for the UART
//               transmitter and receiver on the serial link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        STOP   = 3'b011,
        PARITY = 3'b100
    } state_t;

    // 100 MHz / 9600 baud
    localparam int unsigned BAUD_DIV_DEFAULT = 10417;
    localparam int unsigned DATA_BITS        = 8;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_send.sv
// ============================================================================
// Module      : uart_send
// Description : UART transmitter, 8N1 frames behind a one-entry holding
//               register so consecutive bytes leave with no idle gap.
//               Define UART_SEND_PARITY_EN to insert an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_send
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 dout
);

    localparam int unsigned c_cnt_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned c_bit_w = $clog2(DATA_BITS);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_BITS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_baud_cnt;
    logic [c_cnt_w-1:0]     w_baud_nxt;
    logic [c_bit_w-1:0]     r_bit_cnt;
    logic [c_bit_w-1:0]     w_bit_nxt;
    logic [c_bit_w-1:0]     w_bit_inc;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_hold_full;
    logic                   r_dout;
    logic                   w_dout_nxt;
    logic                   w_load;
    logic                   w_accept;
    logic                   w_bit_end;

    assign w_accept  = valid && !r_hold_full;
    assign w_bit_end = (r_baud_cnt == c_baud_last);
    assign w_bit_inc = r_bit_cnt + c_bit_w'(1);

    assign ready = !r_hold_full;
    assign busy  = (r_state != IDLE) || r_hold_full;
    assign dout  = r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_dout     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_dout     <= w_dout_nxt;
        end
    end

    // Load and accept are mutually exclusive: load needs a full holding
    // register, accept needs an empty one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_shift     <= '0;
        end else begin
            if (w_load) begin
                r_hold_full <= 1'b0;
                r_shift     <= r_hold;
            end else if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold      <= data;
            end
        end
    end

    // dout_nxt always carries the value of the bit that the next state
    // represents, so the registered line switches exactly on bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + c_cnt_w'(1);
        w_bit_nxt   = r_bit_cnt;
        w_dout_nxt  = r_dout;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_dout_nxt = 1'b1;
                if (r_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = START;
                    w_dout_nxt  = 1'b0;
                end
            end
            START: begin
                w_dout_nxt = 1'b0;
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                    w_dout_nxt  = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == c_bit_last) begin
                        w_bit_nxt = '0;
`ifdef UART_SEND_PARITY_EN
                        w_state_nxt = PARITY;
                        w_dout_nxt  = ^r_shift;
`else
                        w_state_nxt = STOP;
                        w_dout_nxt  = 1'b1;
`endif
                    end else begin
                        w_bit_nxt  = w_bit_inc;
                        w_dout_nxt = r_shift[w_bit_inc];
                    end
                end
            end
`ifdef UART_SEND_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = STOP;
                    w_dout_nxt  = 1'b1;
                end
            end
`endif
            STOP: begin
                w_dout_nxt = 1'b1;
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_state_nxt = START;
                        w_dout_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_dout_nxt  = 1'b1;
            end
        endcase
    end

endmodule : uart_send

`default_nettype wire
